// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder_pkg
// Purpose : Shared types and constants for the data-memory responder:
//           FSM state encoding, captured-request and response records,
//           and a helper that detects sub-word (misaligned) byte addresses.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } Dmem_state;

  typedef struct packed {
    logic                   write;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } Dmem_req;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   err;
  } Dmem_rsp;

  // True when the byte address does not point at the first byte of a word.
  function automatic logic word_misaligned(input logic [DMEM_ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module  : dmem_array
// Purpose : Single-port synchronous RAM, DEPTH x 32. When en is high the
//           addressed word is registered onto rdata and, if we is high,
//           overwritten with wdata on the same edge (rdata returns the old
//           word in that case). Contents are never reset.
// Ports   : clk   - clock
//           en    - access enable
//           we    - write enable (qualified by en)
//           idx   - word index
//           wdata - write data
//           rdata - registered read data
// Revision: 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem_q [DEPTH];
  logic [DMEM_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= wdata;
      end
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Purpose : Data-memory responder with a fixed number of wait states. One
//           request is accepted from IDLE, the FSM counts WAIT_CYCLES wait
//           states, then commits the access to the array on the edge that
//           enters RESP and holds the response until the initiator takes it.
// Config  : DMEM_ALIGN_CHECK_EN - when defined, misaligned byte addresses
//           complete with rsp_err=1, rsp_rdata=0 and no array write. When
//           undefined, req_addr[1:0] is ignored and rsp_err is always 0.
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous active-low reset
//           req_valid - request present          req_ready - accept possible
//           req_write - 1 store / 0 load         req_addr  - byte address
//           req_wdata - store data
//           rsp_valid - response present         rsp_ready - response taken
//           rsp_rdata - load data (0 for stores) rsp_err   - request rejected
//           busy      - transaction outstanding (stall input for hazards)
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2     // legal range 0..15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [DMEM_ADDR_W-1:0] req_addr,
  input  logic [DMEM_DATA_W-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DMEM_DATA_W-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  Dmem_state state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  Dmem_req    req_q, req_d;
  logic       err_q, err_d;

  logic                   accept;
  logic                   commit;
  logic                   misalign;
  logic                   arr_we;
  logic [IDX_W-1:0]       arr_idx;
  logic [DMEM_DATA_W-1:0] arr_rdata;
  Dmem_rsp                rsp;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = word_misaligned(req_addr);
`else
  assign misalign = 1'b0;
`endif

  // Gated by rst so the handshake is closed while reset is held low.
  assign req_ready = rst && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d.write = req_write;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          err_d       = misalign;
          cnt_d       = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            // No wait states: the accept edge is also the commit edge.
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // req_d/err_d carry the request being committed in both paths: the live
  // inputs on a zero-wait accept, the captured copy when leaving WAIT.
  assign arr_we  = commit && req_d.write && !err_d;
  assign arr_idx = IDX_W'(req_d.addr[DMEM_ADDR_W-1:2]);

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (commit),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (req_d.wdata),
    .rdata (arr_rdata)
  );

  // The array only re-reads on a commit, so arr_rdata is frozen throughout
  // RESP; masking by state keeps outputs at 0 in reset and outside RESP.
  always_comb begin
    rsp.rdata = '0;
    rsp.err   = 1'b0;
    if (state_q == RESP) begin
      rsp.err = err_q;
      if (!req_q.write && !err_q) begin
        rsp.rdata = arr_rdata;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp.rdata;
  assign rsp_err   = rsp.err;
  assign busy      = (state_q != IDLE);

endmodule : dmem_responder
`default_nettype wire
